tick_divider: RTL and testbench
===============================

Name: tick_divider

Overview:
- Parametrised programmable clock-enable generator; next generation of the team's divider + T flip-flop pair.
- Produces a single-cycle `tick` strobe, a toggle output `q` and a square-wave output `sq`, all in the `clk` domain.
- No derived clocks: downstream logic uses `tick` as an enable.
- Divisor is runtime-loadable through a shadow register that takes effect only at a period boundary.

Parameters:
- CNT_W, 28, width of the period counter and of the divisor.
- DEFAULT_DIV, 100000000, divisor after reset; must be >= 1 and < 2**CNT_W.
- TICKCNT_W, 16, width of `tick_cnt` (optional feature only).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable; when low, counter and outputs hold.
- clr  in  1  synchronous restart of period and phase.
- div_load  in  1  capture `div_value` into the shadow register.
- div_value  in  CNT_W  new divisor; 0 is clamped to 1.
- tick  out  1  one-cycle strobe, once per `div_active` enabled cycles.
- q  out  1  toggles on every tick; period = 2 x div_active.
- sq  out  1  square wave, one period per div_active cycles.
- div_active  out  CNT_W  divisor currently in use.

Behaviour:
- Reset (reset_n low, async):
  - cnt=0, tick=0, q=0, sq=1, div_active=DEFAULT_DIV, pending=0.
  - Outputs are valid from the first edge after release.
- Counter:
  - cnt runs 0..div_active-1 while en=1.
  - wrap = en & (cnt == div_active-1).
  - On wrap: cnt<=0, tick<=1, q<=~q.
  - Otherwise, if en: cnt<=cnt+1 and tick<=0.
  - So tick is high exactly during the cycle in which cnt==0 after a wrap. Latency from wrap edge to tick is 0 cycles: tick is registered on the wrap edge.
- en=0: cnt, q and sq hold; tick<=0.
- sq:
  - Registered; sq<=(next_cnt < ceil(div_active/2)), where next_cnt is the value cnt takes at that edge.
  - Odd divisors: high phase is the longer one.
  - div_active==1: sq<=~q_next, i.e. sq equals the inverse of q.
- Shadow divisor:
  - div_load: pending<=1, div_pend<=max(div_value,1).
  - Loads before a wrap: last one wins.
  - On wrap with pending=1: div_active<=div_pend, pending<=0.
  - div_load on the same edge as wrap: the new value bypasses and becomes div_active immediately; pending<=0.
  - en=0 with pending=1: div_active<=div_pend on the next edge and cnt<=0. Reprogramming while stopped never waits for a wrap.
- Shrinking divisor: when a new div_active <= the old cnt cannot arise, because the change applies only at cnt=0.
- clr (priority over everything except reset):
  - cnt<=0, tick<=0, q<=0, sq<=1.
  - Pending divisor (or a simultaneous div_load) is applied at once.
- Arithmetic: unsigned, CNT_W bits. The counter never exceeds div_active-1, so no overflow.

Optional Feature:
- Macro: TICK_DIVIDER_TICK_COUNT_EN.
- Defined:
  - Adds output `tick_cnt [TICKCNT_W-1:0]`, reset 0.
  - Increments on every wrap, wrapping from all-ones to 0.
  - Cleared by clr.
- Undefined: port and register absent. All other behaviour is identical.

Decomposition:
- Package `tick_divider_pkg`:
  - localparam CNT_W_DEF=28 and DEFAULT_DIV_DEF=100000000.
  - Function `clamp_div` (0 -> 1).
- Single module; no sub-module. Shadow-register logic is too small to justify one.

Test Plan:
- DEFAULT_DIV=4, en=1 after reset -> tick high 1 cycle in every 4; q period 8 cycles; sq 2 high / 2 low; first tick 4 cycles after release.
- div_load=1, div_value=6 at cnt=1 (div_active=4) -> current period finishes at 4; next periods are 6; div_active changes on the wrap edge.
- div_value=0 loaded -> div_active=1; tick high every cycle; q toggles every cycle; sq = ~q.
- en low for 10 cycles at cnt=2 -> cnt, q and sq frozen, tick=0; resumes with tick 2 cycles after en returns.
- clr at cnt=3 with pending div 5 -> next cycle cnt=0, q=0, tick=0, div_active=5; next tick 5 cycles later.
- reset_n pulsed low mid-period (asynchronous, not clock-aligned) -> outputs reach reset values without waiting for a clk edge; with TICK_DIVIDER_TICK_COUNT_EN, tick_cnt=0 and it reaches 3 after 3 periods.

Source files
------------

// File: rtl/tick_divider_pkg.sv
// Shared constants and helpers for the tick_divider clock-enable generator.
package tick_divider_pkg;

    localparam int unsigned CNT_W_DEF       = 28;
    localparam int unsigned DEFAULT_DIV_DEF = 100000000;

    // A zero divisor would never wrap; treat it as divide-by-one.
    function automatic logic [63:0] clamp_div(input logic [63:0] div);
        return (div == 64'd0) ? 64'd1 : div;
    endfunction

endpackage

// File: rtl/tick_divider_if.sv
// Control/status bundle for tick_divider.
// TICK_DIVIDER_TICK_COUNT_EN adds the tick_cnt wrap counter.
interface tick_divider_if #(
    parameter int unsigned CNT_W     = 28,
    parameter int unsigned TICKCNT_W = 16
);

    logic             en;
    logic             clr;
    logic             div_load;
    logic [CNT_W-1:0] div_value;
    logic             tick;
    logic             q;
    logic             sq;
    logic [CNT_W-1:0] div_active;
`ifdef TICK_DIVIDER_TICK_COUNT_EN
    logic [TICKCNT_W-1:0] tick_cnt;

    modport master (
        output en, clr, div_load, div_value,
        input  tick, q, sq, div_active, tick_cnt
    );
    modport slave (
        input  en, clr, div_load, div_value,
        output tick, q, sq, div_active, tick_cnt
    );
`else
    modport master (
        output en, clr, div_load, div_value,
        input  tick, q, sq, div_active
    );
    modport slave (
        input  en, clr, div_load, div_value,
        output tick, q, sq, div_active
    );
`endif

endinterface

// File: rtl/tick_divider.sv
// Programmable clock-enable generator: tick strobe, toggle q and square wave sq.
// Define TICK_DIVIDER_TICK_COUNT_EN to add the tick_cnt wrap counter output.
module tick_divider
    import tick_divider_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
    parameter int unsigned TICKCNT_W   = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    tick_divider_if.slave  bus
);

    localparam logic [CNT_W-1:0] One = CNT_W'(1);

    if (DEFAULT_DIV < 1 || (64'(DEFAULT_DIV) >> CNT_W) != 64'd0 || TICKCNT_W == 0)
    begin : g_param_check
        $error("tick_divider: DEFAULT_DIV or TICKCNT_W out of range");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             q_q, q_d;
    logic             sq_q, sq_d;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] half;
    logic             wrap;

    always_comb begin
        load_val   = CNT_W'(clamp_div(64'(bus.div_value)));
        wrap       = bus.en && (cnt_q == div_q - One);
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        tick_d     = 1'b0;
        q_d        = q_q;

        if (bus.clr) begin
            cnt_d  = '0;
            q_d    = 1'b0;
            pend_d = 1'b0;
            if (bus.div_load) begin
                div_d = load_val;
            end else if (pend_q) begin
                div_d = pend_div_q;
            end
        end else if (!bus.en) begin
            // Stopped: a pending divisor is applied right away instead of waiting for a wrap.
            if (pend_q) begin
                cnt_d  = '0;
                div_d  = bus.div_load ? load_val : pend_div_q;
                pend_d = 1'b0;
            end else if (bus.div_load) begin
                pend_d     = 1'b1;
                pend_div_d = load_val;
            end
        end else if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            q_d    = ~q_q;
            pend_d = 1'b0;
            if (bus.div_load) begin
                div_d = load_val;
            end else if (pend_q) begin
                div_d = pend_div_q;
            end
        end else begin
            cnt_d = cnt_q + One;
            if (bus.div_load) begin
                pend_d     = 1'b1;
                pend_div_d = load_val;
            end
        end

        // sq follows the next-state phase so it stays aligned across divisor changes.
        half = (div_d >> 1) + CNT_W'(div_d[0]);
        sq_d = (div_d == One) ? ~q_d : (cnt_d < half);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            div_q      <= CNT_W'(DEFAULT_DIV);
            pend_div_q <= CNT_W'(DEFAULT_DIV);
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            q_q        <= 1'b0;
            sq_q       <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            q_q        <= q_d;
            sq_q       <= sq_d;
        end
    end

    assign bus.tick       = tick_q;
    assign bus.q          = q_q;
    assign bus.sq         = sq_q;
    assign bus.div_active = div_q;

`ifdef TICK_DIVIDER_TICK_COUNT_EN
    logic [TICKCNT_W-1:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (bus.clr) begin
            tick_cnt_d = '0;
        end else if (wrap) begin
            tick_cnt_d = tick_cnt_q + TICKCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign bus.tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_tick_divider.sv
// Self-checking bench for tick_divider: directed table, corner sequences, random vs. model.
module tb_tick_divider;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned DEFAULT_DIV = 4;
    localparam int unsigned TICKCNT_W   = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    tick_divider_if #(.CNT_W(CNT_W), .TICKCNT_W(TICKCNT_W)) bus ();

    tick_divider #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .TICKCNT_W   (TICKCNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: position within the period, active/pending divisor, wraps since clear.
    int unsigned m_pos, m_div, m_pend, m_wraps;
    bit          m_has_pend, m_tick;

    typedef struct {
        bit          en, clr, ld;
        int unsigned val;
        bit          tick, q, sq;
        int unsigned div;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_div = DEFAULT_DIV; m_pend = 0; m_has_pend = 0; m_wraps = 0; m_tick = 0;
    endtask

    function automatic bit model_q();
        return (m_wraps % 2) == 1;
    endfunction

    function automatic bit model_sq();
        if (m_div == 1) return !model_q();
        return m_pos < (m_div + 1) / 2;
    endfunction

    task automatic model_step(input bit en, input bit clr, input bit ld, input int unsigned val);
        int unsigned nv;
        nv     = (val == 0) ? 1 : val;
        m_tick = 0;
        if (clr) begin
            if (ld) m_div = nv;
            else if (m_has_pend) m_div = m_pend;
            m_has_pend = 0; m_pos = 0; m_wraps = 0;
        end else if (!en) begin
            if (m_has_pend) begin
                m_div = ld ? nv : m_pend; m_has_pend = 0; m_pos = 0;
            end else if (ld) begin
                m_pend = nv; m_has_pend = 1;
            end
        end else if (m_pos + 1 == m_div) begin
            m_tick = 1; m_wraps++; m_pos = 0;
            if (ld) m_div = nv;
            else if (m_has_pend) m_div = m_pend;
            m_has_pend = 0;
        end else begin
            m_pos++;
            if (ld) begin m_pend = nv; m_has_pend = 1; end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".tick"}, 64'(bus.tick), 64'(m_tick));
        check({tag, ".q"}, 64'(bus.q), 64'(model_q()));
        check({tag, ".sq"}, 64'(bus.sq), 64'(model_sq()));
        check({tag, ".div_active"}, 64'(bus.div_active), 64'(m_div));
`ifdef TICK_DIVIDER_TICK_COUNT_EN
        check({tag, ".tick_cnt"}, 64'(bus.tick_cnt), 64'(m_wraps % (1 << TICKCNT_W)));
`endif
    endtask

    task automatic cycle(input bit en, input bit clr, input bit ld, input int unsigned val,
                         input string tag);
        bus.en        = en;
        bus.clr       = clr;
        bus.div_load  = ld;
        bus.div_value = CNT_W'(val);
        @(posedge clk);
        #1;
        model_step(en, clr, ld, val);
        check_model(tag);
    endtask

    initial begin
        int unsigned n;
        bit          found;

        tbl[0] = '{1, 0, 0, 0, 0, 0, 1, 4};
        tbl[1] = '{1, 0, 1, 6, 0, 0, 0, 4};
        tbl[2] = '{1, 0, 0, 0, 0, 0, 0, 4};
        tbl[3] = '{1, 0, 0, 0, 1, 1, 1, 6};
        tbl[4] = '{1, 0, 0, 0, 0, 1, 1, 6};
        tbl[5] = '{1, 0, 0, 0, 0, 1, 1, 6};
        tbl[6] = '{1, 0, 0, 0, 0, 1, 0, 6};
        tbl[7] = '{1, 0, 0, 0, 0, 1, 0, 6};
        tbl[8] = '{1, 0, 0, 0, 0, 1, 0, 6};
        tbl[9] = '{1, 0, 0, 0, 1, 0, 1, 6};

        bus.en = 0; bus.clr = 0; bus.div_load = 0; bus.div_value = '0;
        model_reset();
        #12;
        check("reset.tick", 64'(bus.tick), 64'd0);
        check("reset.q", 64'(bus.q), 64'd0);
        check("reset.sq", 64'(bus.sq), 64'd1);
        check("reset.div_active", 64'(bus.div_active), 64'(DEFAULT_DIV));
        #1 reset_n = 1'b1;

        // Divide-by-4 start, then a load of 6 at cnt=1 that lands on the wrap edge.
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].en, tbl[i].clr, tbl[i].ld, tbl[i].val, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.tick_c", i), 64'(bus.tick), 64'(tbl[i].tick));
            check($sformatf("tbl%0d.q_c", i), 64'(bus.q), 64'(tbl[i].q));
            check($sformatf("tbl%0d.sq_c", i), 64'(bus.sq), 64'(tbl[i].sq));
            check($sformatf("tbl%0d.div_c", i), 64'(bus.div_active), 64'(tbl[i].div));
        end

        // clr with a simultaneous load of 4, then freeze at cnt=2 for 10 cycles.
        cycle(1, 1, 1, 4, "clrld");
        check("clrld.div_c", 64'(bus.div_active), 64'd4);
        check("clrld.q_c", 64'(bus.q), 64'd0);
        cycle(1, 0, 0, 0, "pre_hold");
        cycle(1, 0, 0, 0, "pre_hold");
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 0, "hold");
            check("hold.tick_c", 64'(bus.tick), 64'd0);
            check("hold.q_c", 64'(bus.q), 64'd0);
            check("hold.sq_c", 64'(bus.sq), 64'd0);
        end
        cycle(1, 0, 0, 0, "resume1");
        check("resume1.tick_c", 64'(bus.tick), 64'd0);
        cycle(1, 0, 0, 0, "resume2");
        check("resume2.tick_c", 64'(bus.tick), 64'd1);
        check("resume2.q_c", 64'(bus.q), 64'd1);

        // clr at cnt=3 with a pending divisor of 5.
        cycle(1, 0, 1, 5, "pend5");
        cycle(1, 0, 0, 0, "pend5");
        cycle(1, 0, 0, 0, "pend5");
        cycle(1, 1, 0, 0, "clr5");
        check("clr5.tick_c", 64'(bus.tick), 64'd0);
        check("clr5.q_c", 64'(bus.q), 64'd0);
        check("clr5.div_c", 64'(bus.div_active), 64'd5);
        n = 0; found = 0;
        while (!found && n < 20) begin
            cycle(1, 0, 0, 0, "clr5.run");
            n++;
            found = bus.tick;
        end
        check("clr5.tick_latency", 64'(n), 64'd5);

        // Divisor 0 clamps to 1: tick every cycle, q toggles, sq = ~q.
        cycle(1, 1, 1, 0, "div0");
        check("div0.div_c", 64'(bus.div_active), 64'd1);
        for (int i = 1; i <= 6; i++) begin
            cycle(1, 0, 0, 0, "div1");
            check("div1.tick_c", 64'(bus.tick), 64'd1);
            check("div1.q_c", 64'(bus.q), 64'(i % 2));
            check("div1.sq_c", 64'(bus.sq), 64'((i + 1) % 2));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 9) < 8), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) == 0), $urandom_range(0, 9), "rand");
        end

        // Asynchronous reset mid-period, released off the clock edge.
        cycle(1, 0, 0, 0, "pre_rst");
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("arst.tick", 64'(bus.tick), 64'd0);
        check("arst.q", 64'(bus.q), 64'd0);
        check("arst.sq", 64'(bus.sq), 64'd1);
        check("arst.div_active", 64'(bus.div_active), 64'(DEFAULT_DIV));
`ifdef TICK_DIVIDER_TICK_COUNT_EN
        check("arst.tick_cnt", 64'(bus.tick_cnt), 64'd0);
`endif
        #2 reset_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cycle(1, 0, 0, 0, "post_rst");
            check("post_rst.tick_c", 64'(bus.tick), 64'(i % 4 == 0));
        end
        check("post_rst.q_c", 64'(bus.q), 64'd1);
`ifdef TICK_DIVIDER_TICK_COUNT_EN
        check("post_rst.tick_cnt_c", 64'(bus.tick_cnt), 64'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
